avalon_blitter_queue: RTL and testbench
=======================================

Name: avalon_blitter_queue

Overview:
- Parametrised Avalon-MM command queue between the NIOS-II and the blitter, replacing the fixed 8-slot flip-flag ring.
- NIOS-II writes multi-word blit commands into a staging area. Writing the last word pushes the command into a DEPTH-entry FIFO.
- The blitter side pulls commands with a valid/ready handshake and reports completion with a done pulse.
- Adds occupancy/full/overflow status, a completion counter, per-byte write merging and a drain interrupt.

Parameters:
- DEPTH, 16: FIFO entries; power of 2, minimum 2.
- CMD_WORDS, 2: 32-bit words per command; 1..8.
- CNT_W, $clog2(DEPTH)+1: occupancy counter width (derived; not overridden).

Ports:
- CLOCK  in  1  system clock.
- Hard_RESET  in  1  reset.
- AVL_READ  in  1  Avalon read.
- AVL_WRITE  in  1  Avalon write.
- AVL_CS  in  1  chip select.
- AVL_BYTE_EN  in  4  byte enables.
- AVL_ADDR  in  5  word address.
- AVL_WRITEDATA  in  32  write data.
- AVL_READDATA  out  32  read data.
- CMD_VALID  out  1  head command presented to blitter.
- CMD_DATA  out  32*CMD_WORDS  head command; word 0 in the MSBs.
- CMD_READY  in  1  blitter accepts CMD_DATA.
- BLIT_DONE  in  1  one-cycle pulse when the accepted command finishes.
- QUEUE_IRQ  out  1  drain interrupt, level.
- EXPORT_STATUS  out  32  copy of the STATUS register for monitoring.

Interface: one clock; reset is synchronous and active-high. Effective reset RESET = Hard_RESET | soft reset.

Behaviour:
- Access qualifiers: wr = AVL_CS & AVL_WRITE; rd = AVL_CS & AVL_READ. Read latency 0; AVL_READDATA is combinational from AVL_ADDR.
- Address map:
  - 0..CMD_WORDS-1: staging words, R/W.
  - 16 STATUS, RO: [CNT_W-1:0] count, [16] empty, [17] full, [18] overflow (sticky), [19] busy (state != IDLE).
  - 17 DONE_COUNT, RO: 32-bit, wraps to 0.
  - 18 CONTROL: bit0 write-1 clears overflow; bit1 irq_en (R/W).
  - 31: any write is a soft reset, asserted for that cycle only.
  - Any other address reads 0; writes to it are ignored.
- Staging writes merge per enabled byte; disabled bytes keep their old value.
- Commit: a write to word CMD_WORDS-1 pushes the merged staging contents (including that write's bytes) on the same edge.
  - The push is accepted iff !full, or a pop happens in the same cycle.
  - Otherwise the command is dropped, overflow is set to 1, and count is unchanged.
- FIFO: head/tail pointers of $clog2(DEPTH) bits with natural wrap; count in 0..DEPTH.
  - Push and pop in the same cycle: count unchanged.
- State machine (registered state):
  - IDLE: CMD_VALID=0. If count>0, go to ISSUE next cycle.
  - ISSUE: CMD_VALID=1, CMD_DATA=head. If CMD_READY, pop and go to WAIT_DONE. CMD_DATA must stay stable while CMD_VALID & !CMD_READY.
  - WAIT_DONE: CMD_VALID=0. On BLIT_DONE, DONE_COUNT++, then go to ISSUE if count>0 (count evaluated after this cycle's push/pop), else IDLE.
  - BLIT_DONE outside WAIT_DONE is ignored.
  - Latency from first push into an empty idle queue to CMD_VALID: 2 cycles.
  - At most one command is outstanding.
- QUEUE_IRQ: registered; = irq_en & empty & (state==IDLE).
- Reset values: state IDLE; pointers, count, staging, DONE_COUNT, overflow, irq_en all 0. Outputs: CMD_VALID 0, CMD_DATA 0, QUEUE_IRQ 0, EXPORT_STATUS = 0x00010000 (empty).
- Reset mid-operation: queue contents discarded, state returns to IDLE. A BLIT_DONE arriving after the reset is ignored.
- Soft reset and a staging write can never coincide: they are different addresses.

Decomposition:
- Package blitter_pkg holds:
  - address constants: ADDR_STATUS=16, ADDR_DONE=17, ADDR_CTRL=18, ADDR_SRST=31;
  - STATUS bit indices;
  - the state enum {IDLE, ISSUE, WAIT_DONE}.
- One sub-module, blit_cmd_fifo: parametrised synchronous FIFO (DEPTH, WIDTH) with push, pop, head data, count, full and empty.

Test Plan:
- Reset, then read 16 → 0x00010000. CMD_VALID=0, QUEUE_IRQ=0.
- Write word0=0xAABBCCDD, then word1=0x11223344 with CMD_READY=1 → count becomes 1. Two cycles later CMD_VALID=1 and CMD_DATA=0xAABBCCDD11223344. Next cycle count=0, CMD_VALID=0. BLIT_DONE pulse → DONE_COUNT=1.
- Byte merge: write word0=0xFFFFFFFF with BE=1111, then 0x00000012 with BE=0001 → word0 reads 0xFFFFFF12.
- Hold CMD_READY=0 and commit 17 commands (DEPTH=16) → full=1, count=16, overflow=1. Write CONTROL=1 → overflow reads 0.
- Full queue: raise CMD_READY in the same cycle as a commit → push accepted, count stays 16, overflow stays 0.
- Set irq_en and commit 3 commands → QUEUE_IRQ rises 1 cycle after the 3rd BLIT_DONE.
- Soft reset: write address 31 during WAIT_DONE → next cycle count=0 and state IDLE. A later BLIT_DONE leaves DONE_COUNT unchanged.

Source files
------------

// File: rtl/blitter_pkg.sv
// Shared address map, STATUS layout and sequencer states for the blitter command queue.
// No timing of its own; the byte-merge helper is pure combinational.
package blitter_pkg;

    localparam logic [4:0] ADDR_STATUS = 5'd16;
    localparam logic [4:0] ADDR_DONE   = 5'd17;
    localparam logic [4:0] ADDR_CTRL   = 5'd18;
    localparam logic [4:0] ADDR_SRST   = 5'd31;

    localparam int ST_EMPTY = 16;
    localparam int ST_FULL  = 17;
    localparam int ST_OVF   = 18;
    localparam int ST_BUSY  = 19;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_DONE = 2'd2
    } blit_state_e;

    function automatic logic [31:0] be_merge(input logic [31:0] old_w,
                                             input logic [31:0] new_w,
                                             input logic [3:0]  be);
        logic [31:0] m;
        m = old_w;
        for (int b = 0; b < 4; b++) begin
            if (be[b]) m[8*b +: 8] = new_w[8*b +: 8];
        end
        return m;
    endfunction

endpackage

// File: rtl/blit_cmd_fifo.sv
// Synchronous FIFO of command words; head is combinational from storage, push/pop take effect on the edge.
// No internal backpressure: the caller must not push when full unless it pops in the same cycle.
module blit_cmd_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 64,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic [CW-1:0]    count_o,
    output logic             full_o,
    output logic             empty_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    head_q, head_d;
    logic [AW-1:0]    tail_q, tail_d;
    logic [CW-1:0]    count_q, count_d;

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (push_i) tail_d = tail_q + 1'b1;
        if (pop_i)  head_d = head_q + 1'b1;
        if (push_i && !pop_i)      count_d = count_q + 1'b1;
        else if (!push_i && pop_i) count_d = count_q - 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Storage is not reset; consumers only look at it while count is non-zero.
    always_ff @(posedge clk_i) begin
        if (push_i) mem_q[tail_q] <= wdata_i;
    end

    assign rdata_o = mem_q[head_q];
    assign count_o = count_q;
    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);

endmodule

// File: rtl/avalon_blitter_queue.sv
// Avalon-MM staged command queue feeding the blitter; 0-cycle reads, commit-to-CMD_VALID 2 cycles.
// Blitter side is valid/ready with one command outstanding; commits into a full queue are dropped and flagged.
module avalon_blitter_queue
    import blitter_pkg::*;
#(
    parameter int DEPTH     = 16,
    parameter int CMD_WORDS = 2
) (
    input  logic                    CLOCK,
    input  logic                    Hard_RESET,
    input  logic                    AVL_READ,
    input  logic                    AVL_WRITE,
    input  logic                    AVL_CS,
    input  logic [3:0]              AVL_BYTE_EN,
    input  logic [4:0]              AVL_ADDR,
    input  logic [31:0]             AVL_WRITEDATA,
    output logic [31:0]             AVL_READDATA,
    output logic                    CMD_VALID,
    output logic [32*CMD_WORDS-1:0] CMD_DATA,
    input  logic                    CMD_READY,
    input  logic                    BLIT_DONE,
    output logic                    QUEUE_IRQ,
    output logic [31:0]             EXPORT_STATUS
);

    localparam int         CNT_W     = $clog2(DEPTH) + 1;
    localparam int         CMD_W     = 32 * CMD_WORDS;
    localparam logic [4:0] LAST_WORD = 5'(CMD_WORDS - 1);

    logic              wr, rd, srst, rst;
    logic              commit, push_ok, pop, ovf_set, ctrl_wr;
    logic [31:0]       stage_q [CMD_WORDS];
    logic [31:0]       stage_d [CMD_WORDS];
    logic [CMD_W-1:0]  cmd_packed, head_dat;
    logic [CNT_W-1:0]  fifo_count, cnt_after;
    logic              fifo_full, fifo_empty;
    blit_state_e       state_q, state_d;
    logic [31:0]       done_cnt_q;
    logic              ovf_q, ovf_d;
    logic              irq_en_q, irq_en_d;
    logic              irq_q;
    logic [31:0]       status, rdata;

    assign wr      = AVL_CS & AVL_WRITE;
    assign rd      = AVL_CS & AVL_READ;
    assign srst    = wr && (AVL_ADDR == ADDR_SRST);
    assign rst     = Hard_RESET | srst;
    assign ctrl_wr = wr && (AVL_ADDR == ADDR_CTRL);
    assign commit  = wr && (AVL_ADDR == LAST_WORD);
    assign pop     = (state_q == ISSUE) && CMD_READY;
    // A same-cycle pop frees the slot the commit lands in, so full only blocks when nothing leaves.
    assign push_ok = commit && (!fifo_full || pop);
    assign ovf_set = commit && fifo_full && !pop;

    always_comb begin
        cmd_packed = '0;
        for (int w = 0; w < CMD_WORDS; w++) begin
            stage_d[w] = stage_q[w];
            if (wr && (AVL_ADDR == 5'(w)))
                stage_d[w] = be_merge(stage_q[w], AVL_WRITEDATA, AVL_BYTE_EN);
            cmd_packed[CMD_W-1-32*w -: 32] = stage_d[w];
        end
    end

    blit_cmd_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (CMD_W)
    ) u_fifo (
        .clk_i   (CLOCK),
        .rst_i   (rst),
        .push_i  (push_ok),
        .pop_i   (pop),
        .wdata_i (cmd_packed),
        .rdata_o (head_dat),
        .count_o (fifo_count),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    always_comb begin
        cnt_after = fifo_count;
        if (push_ok && !pop)      cnt_after = fifo_count + 1'b1;
        else if (!push_ok && pop) cnt_after = fifo_count - 1'b1;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:      if (fifo_count != '0) state_d = ISSUE;
            ISSUE:     if (CMD_READY) state_d = WAIT_DONE;
            WAIT_DONE: if (BLIT_DONE) state_d = (cnt_after != '0) ? ISSUE : IDLE;
            default:   state_d = IDLE;
        endcase
    end

    always_comb begin
        ovf_d    = ovf_q;
        irq_en_d = irq_en_q;
        if (ctrl_wr) begin
            if (AVL_WRITEDATA[0]) ovf_d = 1'b0;
            irq_en_d = AVL_WRITEDATA[1];
        end
        if (ovf_set) ovf_d = 1'b1;
    end

    always_ff @(posedge CLOCK) begin
        if (rst) begin
            state_q    <= IDLE;
            done_cnt_q <= '0;
            ovf_q      <= 1'b0;
            irq_en_q   <= 1'b0;
            irq_q      <= 1'b0;
            for (int w = 0; w < CMD_WORDS; w++) stage_q[w] <= '0;
        end else begin
            state_q  <= state_d;
            ovf_q    <= ovf_d;
            irq_en_q <= irq_en_d;
            if ((state_q == WAIT_DONE) && BLIT_DONE) done_cnt_q <= done_cnt_q + 1'b1;
            // Built from next-state values so the flop always equals irq_en & empty & idle.
            irq_q <= irq_en_d && (cnt_after == '0) && (state_d == IDLE);
            for (int w = 0; w < CMD_WORDS; w++) stage_q[w] <= stage_d[w];
        end
    end

    always_comb begin
        status                = '0;
        status[CNT_W-1:0]     = fifo_count;
        status[ST_EMPTY]      = fifo_empty;
        status[ST_FULL]       = fifo_full;
        status[ST_OVF]        = ovf_q;
        status[ST_BUSY]       = (state_q != IDLE);
    end

    always_comb begin
        rdata = '0;
        for (int w = 0; w < CMD_WORDS; w++) begin
            if (AVL_ADDR == 5'(w)) rdata = stage_q[w];
        end
        if (AVL_ADDR == ADDR_STATUS) rdata = status;
        if (AVL_ADDR == ADDR_DONE)   rdata = done_cnt_q;
        if (AVL_ADDR == ADDR_CTRL)   rdata = {30'd0, irq_en_q, 1'b0};
    end

    assign AVL_READDATA  = rd ? rdata : 32'd0;
    assign CMD_VALID     = (state_q == ISSUE);
    assign CMD_DATA      = CMD_VALID ? head_dat : '0;
    assign QUEUE_IRQ     = irq_q;
    assign EXPORT_STATUS = status;

endmodule

// File: tb/tb_avalon_blitter_queue.sv
// Directed bench for avalon_blitter_queue: a queue-level model is checked every cycle,
// plus literal expectations at the interesting points of each scenario.
module tb_avalon_blitter_queue;

    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        Hard_RESET = 1'b1;
    logic        AVL_READ = 1'b0, AVL_WRITE = 1'b0, AVL_CS = 1'b0;
    logic [3:0]  AVL_BYTE_EN = 4'hF;
    logic [4:0]  AVL_ADDR = 5'd0;
    logic [31:0] AVL_WRITEDATA = 32'd0;
    logic [31:0] AVL_READDATA;
    logic        CMD_VALID;
    logic [63:0] CMD_DATA;
    logic        CMD_READY = 1'b0, BLIT_DONE = 1'b0;
    logic        QUEUE_IRQ;
    logic [31:0] EXPORT_STATUS;

    int total = 0;
    int bad   = 0;

    avalon_blitter_queue #(.DEPTH(DEPTH), .CMD_WORDS(2)) dut (
        .CLOCK         (clk),
        .Hard_RESET    (Hard_RESET),
        .AVL_READ      (AVL_READ),
        .AVL_WRITE     (AVL_WRITE),
        .AVL_CS        (AVL_CS),
        .AVL_BYTE_EN   (AVL_BYTE_EN),
        .AVL_ADDR      (AVL_ADDR),
        .AVL_WRITEDATA (AVL_WRITEDATA),
        .AVL_READDATA  (AVL_READDATA),
        .CMD_VALID     (CMD_VALID),
        .CMD_DATA      (CMD_DATA),
        .CMD_READY     (CMD_READY),
        .BLIT_DONE     (BLIT_DONE),
        .QUEUE_IRQ     (QUEUE_IRQ),
        .EXPORT_STATUS (EXPORT_STATUS)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Queue-level model: a list of committed commands plus "offered" / "in flight" flags.
    bit [63:0]   mq[$];
    bit [31:0]   ms [2];
    bit          m_ovf, m_irq_en, m_offer, m_out, m_irq;
    int unsigned m_done;
    bit          chk_en = 1'b0;

    function automatic logic [31:0] exp_status();
        logic [31:0] s;
        s = 32'd0;
        s[4:0] = 5'(mq.size());
        s[16]  = (mq.size() == 0);
        s[17]  = (mq.size() == DEPTH);
        s[18]  = m_ovf;
        s[19]  = m_offer || m_out;
        return s;
    endfunction

    always @(posedge clk) begin
        bit wr_b, pop_b, full_b;
        int sz0;
        wr_b = AVL_CS && AVL_WRITE;
        if (Hard_RESET || (wr_b && AVL_ADDR == 5'd31)) begin
            mq.delete();
            ms[0] = 0; ms[1] = 0;
            m_ovf = 0; m_irq_en = 0; m_offer = 0; m_out = 0; m_irq = 0; m_done = 0;
            chk_en = 1'b1;
        end else begin
            sz0    = mq.size();
            full_b = (sz0 == DEPTH);
            pop_b  = m_offer && CMD_READY;
            if (pop_b) void'(mq.pop_front());
            if (wr_b && AVL_ADDR < 5'd2)
                for (int b = 0; b < 4; b++)
                    if (AVL_BYTE_EN[b]) ms[AVL_ADDR[0]][8*b +: 8] = AVL_WRITEDATA[8*b +: 8];
            if (wr_b && AVL_ADDR == 5'd1) begin
                if (!full_b || pop_b) mq.push_back({ms[0], ms[1]});
                else m_ovf = 1;
            end
            if (wr_b && AVL_ADDR == 5'd18) begin
                if (AVL_WRITEDATA[0]) m_ovf = 0;
                m_irq_en = AVL_WRITEDATA[1];
            end
            if (m_offer) begin
                if (pop_b) begin m_offer = 0; m_out = 1; end
            end else if (m_out) begin
                if (BLIT_DONE) begin
                    m_done++;
                    m_out   = 0;
                    m_offer = (mq.size() != 0);
                end
            end else begin
                m_offer = (sz0 != 0);
            end
            m_irq = m_irq_en && (mq.size() == 0) && !m_offer && !m_out;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("cmd_valid", 64'(CMD_VALID), 64'(m_offer));
            if (m_offer) chk("cmd_data", CMD_DATA, mq[0]);
            else         chk("cmd_data_idle", CMD_DATA, 64'd0);
            chk("queue_irq", 64'(QUEUE_IRQ), 64'(m_irq));
            chk("export_status", 64'(EXPORT_STATUS), 64'(exp_status()));
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d, input logic [3:0] be = 4'hF);
        AVL_CS = 1'b1; AVL_WRITE = 1'b1; AVL_ADDR = a; AVL_WRITEDATA = d; AVL_BYTE_EN = be;
        cyc();
        AVL_CS = 1'b0; AVL_WRITE = 1'b0;
    endtask

    task automatic rd_chk(input string nm, input logic [4:0] a, input logic [31:0] exp);
        AVL_CS = 1'b1; AVL_READ = 1'b1; AVL_ADDR = a;
        #1;
        chk(nm, 64'(AVL_READDATA), 64'(exp));
        AVL_CS = 1'b0; AVL_READ = 1'b0;
    endtask

    task automatic done_pulse();
        BLIT_DONE = 1'b1;
        cyc();
        BLIT_DONE = 1'b0;
    endtask

    initial begin
        repeat (3) cyc();
        Hard_RESET = 1'b0;

        // Reset state.
        rd_chk("reset_status", 5'd16, 32'h0001_0000);
        chk("reset_valid", 64'(CMD_VALID), 64'd0);
        chk("reset_irq", 64'(QUEUE_IRQ), 64'd0);

        // Single command, two-cycle issue latency.
        CMD_READY = 1'b1;
        wr(5'd0, 32'hAABB_CCDD);
        wr(5'd1, 32'h1122_3344);
        chk("count_after_commit", 64'(EXPORT_STATUS[4:0]), 64'd1);
        chk("valid_one_after", 64'(CMD_VALID), 64'd0);
        cyc();
        chk("valid_two_after", 64'(CMD_VALID), 64'd1);
        chk("first_cmd_data", CMD_DATA, 64'hAABB_CCDD_1122_3344);
        cyc();
        chk("count_after_pop", 64'(EXPORT_STATUS[4:0]), 64'd0);
        chk("valid_after_pop", 64'(CMD_VALID), 64'd0);
        done_pulse();
        rd_chk("done_count_1", 5'd17, 32'd1);

        // Per-byte write merge.
        wr(5'd0, 32'hFFFF_FFFF, 4'b1111);
        wr(5'd0, 32'h0000_0012, 4'b0001);
        rd_chk("byte_merge", 5'd0, 32'hFFFF_FF12);

        // Overflow: 17 commits with the blitter stalled.
        CMD_READY = 1'b0;
        for (int i = 0; i < 17; i++) wr(5'd1, 32'(i));
        rd_chk("status_overflow", 5'd16, 32'h000E_0010);
        wr(5'd18, 32'd1);
        rd_chk("status_ovf_cleared", 5'd16, 32'h000A_0010);

        // Commit into a full queue in the same cycle as a pop.
        CMD_READY = 1'b1;
        wr(5'd1, 32'h0000_0055);
        rd_chk("full_push_pop", 5'd16, 32'h000A_0010);

        // Drain everything.
        for (int i = 0; i < 16; i++) begin
            done_pulse();
            cyc();
        end
        done_pulse();
        rd_chk("done_count_18", 5'd17, 32'd18);
        rd_chk("status_drained", 5'd16, 32'h0001_0000);

        // Drain interrupt after the third completion.
        wr(5'd18, 32'd2);
        rd_chk("ctrl_readback", 5'd18, 32'd2);
        wr(5'd1, 32'hA);
        wr(5'd1, 32'hB);
        wr(5'd1, 32'hC);
        for (int i = 0; i < 3; i++) begin
            if (i == 2) chk("irq_before_last_done", 64'(QUEUE_IRQ), 64'd0);
            done_pulse();
            if (i < 2) cyc();
        end
        chk("irq_after_last_done", 64'(QUEUE_IRQ), 64'd1);

        // Soft reset while a command is in flight.
        wr(5'd1, 32'h1);
        wr(5'd1, 32'h2);
        cyc();
        chk("busy_before_srst", 64'(EXPORT_STATUS[19]), 64'd1);
        wr(5'd31, 32'd0);
        rd_chk("status_after_srst", 5'd16, 32'h0001_0000);
        rd_chk("stage_after_srst", 5'd0, 32'd0);
        chk("irq_after_srst", 64'(QUEUE_IRQ), 64'd0);
        done_pulse();
        rd_chk("done_after_srst", 5'd17, 32'd0);

        // Unmapped address ignores writes and reads zero.
        wr(5'd5, 32'hDEAD_BEEF);
        rd_chk("unmapped_read", 5'd5, 32'd0);
        cyc();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
